// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry path: default operand
// width and the operand sequencer phase encoding.
package calc_pkg;

  localparam int W_DEF = 3;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    CALC  = 2'd2,
    SHOW  = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  // Synchronize, count consecutive samples that disagree with the accepted level, pulse on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        // The new level has now been seen DEBOUNCE_CYCLES times in a row.
        level_r <= sync2_r;
        cnt_r   <= CNT_ZERO;
        press_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/calc_operand_ctrl.sv
// Operand-entry sequencer feeding adder3: captures A then B from the switches
// on ENTER, latches the sum for display, and returns to A entry on ENTER/CLEAR.
module calc_operand_ctrl
  import calc_pkg::*;
#(
  parameter int W               = W_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         btn_enter,
  input  logic         btn_clear,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic [W:0]   sum_in,
  output logic [W:0]   result,
  output logic         result_valid,
  output logic         want_a,
  output logic         want_b
);

  localparam logic [W-1:0] OP_ZERO  = {W{1'b0}};
  localparam logic [W:0]   SUM_ZERO = {(W + 1){1'b0}};

  logic [W-1:0] sw_meta_r;
  logic [W-1:0] sw_sync_r;
  logic         enter_press_s;
  logic         clear_press_s;

  state_e       state_r;
  state_e       state_s;
  logic [W-1:0] op_a_r;
  logic [W-1:0] op_a_s;
  logic [W-1:0] op_b_r;
  logic [W-1:0] op_b_s;
  logic [W:0]   result_r;
  logic [W:0]   result_s;
  logic         valid_r;
  logic         valid_s;
  logic         want_a_r;
  logic         want_b_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .press (enter_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (clear_press_s)
  );

  // Two-stage synchronizer for the operand switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_r <= OP_ZERO;
      sw_sync_r <= OP_ZERO;
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Next phase and next operand/result values; CLEAR overrides ENTER.
  always_comb begin
    state_s  = state_r;
    op_a_s   = op_a_r;
    op_b_s   = op_b_r;
    result_s = result_r;
    valid_s  = valid_r;
    if (clear_press_s) begin
      state_s  = GET_A;
      op_a_s   = OP_ZERO;
      op_b_s   = OP_ZERO;
      result_s = SUM_ZERO;
      valid_s  = 1'b0;
    end else begin
      case (state_r)
        GET_A: begin
          if (enter_press_s) begin
            op_a_s  = sw_sync_r;
            state_s = GET_B;
          end else begin
            state_s = GET_A;
          end
        end
        GET_B: begin
          if (enter_press_s) begin
            op_b_s  = sw_sync_r;
            state_s = CALC;
          end else begin
            state_s = GET_B;
          end
        end
        CALC: begin
          // op_a/op_b settled last edge, so the adder output is valid now.
          result_s = sum_in;
          valid_s  = 1'b1;
          state_s  = SHOW;
        end
        SHOW: begin
          if (enter_press_s) begin
            valid_s = 1'b0;
            state_s = GET_A;
          end else begin
            state_s = SHOW;
          end
        end
        default: begin
          state_s = GET_A;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // Phase, operand, result and LED registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= GET_A;
      op_a_r   <= OP_ZERO;
      op_b_r   <= OP_ZERO;
      result_r <= SUM_ZERO;
      valid_r  <= 1'b0;
      want_a_r <= 1'b1;
      want_b_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      op_a_r   <= op_a_s;
      op_b_r   <= op_b_s;
      result_r <= result_s;
      valid_r  <= valid_s;
      want_a_r <= (state_s == GET_A);
      want_b_r <= (state_s == GET_B);
    end
  end

  assign op_a         = op_a_r;
  assign op_b         = op_b_r;
  assign result       = result_r;
  assign result_valid = valid_r;
  assign want_a       = want_a_r;
  assign want_b       = want_b_r;

endmodule

// File: tb/tb_calc_operand_ctrl.sv
// Bench for calc_operand_ctrl with an adder3 stand-in, a behavioural model
// checked every cycle, directed scenarios and randomized button/switch traffic.
module tb_calc_operand_ctrl;

  localparam int W  = 3;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_enter = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W:0]   sum_in;
  logic [W:0]   result;
  logic         result_valid;
  logic         want_a;
  logic         want_b;

  int checks = 0;
  int errors = 0;

  calc_operand_ctrl #(.W(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .op_a         (op_a),
    .op_b         (op_b),
    .sum_in       (sum_in),
    .result       (result),
    .result_valid (result_valid),
    .want_a       (want_a),
    .want_b       (want_b)
  );

  // adder3 stand-in
  assign sum_in = {1'b0, op_a} + {1'b0, op_b};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = entering A, 1 = entering B, 2 = computing, 3 = showing
  int           m_phase = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W:0]   m_res = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_sw_pipe [2];
  logic         m_e_pipe [2];
  logic         m_c_pipe [2];
  logic         m_e_deb = 1'b0;
  logic         m_c_deb = 1'b0;
  logic         m_e_press = 1'b0;
  logic         m_c_press = 1'b0;
  logic         m_e_hist [$];
  logic         m_c_hist [$];
  bit           armed = 1'b0;

  function automatic bit all_differ(input logic q [$], input logic d);
    foreach (q[i]) if (q[i] === d) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic         e_s;
    logic         c_s;
    logic [W-1:0] swv;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_a = '0; m_b = '0; m_res = '0; m_valid = 1'b0;
        m_sw_pipe[0] = '0; m_sw_pipe[1] = '0;
        m_e_pipe[0] = 1'b0; m_e_pipe[1] = 1'b0;
        m_c_pipe[0] = 1'b0; m_c_pipe[1] = 1'b0;
        m_e_deb = 1'b0; m_c_deb = 1'b0;
        m_e_press = 1'b0; m_c_press = 1'b0;
        m_e_hist.delete(); m_c_hist.delete();
        armed = 1'b1;
      end else begin
        swv = m_sw_pipe[1];
        if (m_c_press) begin
          m_phase = 0; m_a = '0; m_b = '0; m_res = '0; m_valid = 1'b0;
        end else begin
          case (m_phase)
            0: if (m_e_press) begin m_a = swv; m_phase = 1; end
            1: if (m_e_press) begin m_b = swv; m_phase = 2; end
            2: begin m_res = m_a + m_b + 4'd0; m_valid = 1'b1; m_phase = 3; end
            default: if (m_e_press) begin m_valid = 1'b0; m_phase = 0; end
          endcase
        end
        // a button level is accepted once the last DB synced samples all disagree with it
        e_s = m_e_pipe[1];
        c_s = m_c_pipe[1];
        m_e_hist.push_back(e_s);
        if (m_e_hist.size() > DB) void'(m_e_hist.pop_front());
        m_c_hist.push_back(c_s);
        if (m_c_hist.size() > DB) void'(m_c_hist.pop_front());
        m_e_press = 1'b0;
        m_c_press = 1'b0;
        if (m_e_hist.size() == DB && all_differ(m_e_hist, m_e_deb)) begin
          m_e_deb = e_s; m_e_press = e_s;
        end
        if (m_c_hist.size() == DB && all_differ(m_c_hist, m_c_deb)) begin
          m_c_deb = c_s; m_c_press = c_s;
        end
        m_sw_pipe[1] = m_sw_pipe[0]; m_sw_pipe[0] = sw;
        m_e_pipe[1] = m_e_pipe[0];   m_e_pipe[0] = btn_enter;
        m_c_pipe[1] = m_c_pipe[0];   m_c_pipe[0] = btn_clear;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("op_a",         32'(op_a),         32'(m_a));
        chk("op_b",         32'(op_b),         32'(m_b));
        chk("result",       32'(result),       32'(m_res));
        chk("result_valid", 32'(result_valid), 32'(m_valid));
        chk("want_a",       32'(want_a),       32'(m_phase == 0));
        chk("want_b",       32'(want_b),       32'(m_phase == 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_enter(input int n);
    btn_enter = 1'b1;
    cyc(n);
    btn_enter = 1'b0;
    cyc(12);
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1;
    cyc(3);
    chk("rst_op_a",   32'(op_a),         32'd0);
    chk("rst_result", 32'(result),       32'd0);
    chk("rst_valid",  32'(result_valid), 32'd0);
    chk("rst_want_a", 32'(want_a),       32'd1);
    rst = 1'b0;
    cyc(2);

    sw = 3'd3; cyc(3); hold_enter(10);
    sw = 3'd5; cyc(3); hold_enter(10);
    chk("lit_a3",      32'(op_a),         32'd3);
    chk("lit_b5",      32'(op_b),         32'd5);
    chk("lit_sum8",    32'(result),       32'h8);
    chk("lit_valid",   32'(result_valid), 32'd1);
    chk("lit_show_wa", 32'(want_a),       32'd0);
    chk("lit_show_wb", 32'(want_b),       32'd0);

    hold_enter(10);
    sw = 3'd7; cyc(3); hold_enter(10); hold_enter(10);
    chk("lit_sumE",  32'(result),       32'hE);
    chk("lit_validE", 32'(result_valid), 32'd1);
    hold_enter(10);
    chk("lit_ack_valid", 32'(result_valid), 32'd0);
    chk("lit_ack_want_a", 32'(want_a),      32'd1);
    chk("lit_keepE",     32'(result),       32'hE);

    // bounce: two short pulses rejected, then one stable press
    sw = 3'd2; cyc(3);
    repeat (2) begin
      btn_enter = 1'b1; cyc(2);
      btn_enter = 1'b0; cyc(2);
    end
    btn_enter = 1'b1; cyc(6);
    btn_enter = 1'b0; cyc(12);
    chk("lit_bounce_wb", 32'(want_b), 32'd1);
    chk("lit_bounce_a",  32'(op_a),   32'd2);

    btn_clear = 1'b1; cyc(10); btn_clear = 1'b0; cyc(12);
    chk("lit_clr_wa", 32'(want_a), 32'd1);
    chk("lit_clr_a",  32'(op_a),   32'd0);

    // enter and clear together in GET_B: clear wins
    sw = 3'd4; cyc(3); hold_enter(10);
    chk("lit_getb_a4", 32'(op_a), 32'd4);
    btn_enter = 1'b1; btn_clear = 1'b1; cyc(10);
    btn_enter = 1'b0; btn_clear = 1'b0; cyc(12);
    chk("lit_both_wa",    32'(want_a),       32'd1);
    chk("lit_both_a",     32'(op_a),         32'd0);
    chk("lit_both_b",     32'(op_b),         32'd0);
    chk("lit_both_valid", 32'(result_valid), 32'd0);

    // reset while computing
    sw = 3'd6; cyc(3); hold_enter(10);
    sw = 3'd1; cyc(3);
    btn_enter = 1'b1;
    for (int i = 0; i < 30 && want_b; i++) cyc(1);
    chk("calc_reached", 32'(want_b), 32'd0);
    rst = 1'b1; btn_enter = 1'b0;
    cyc(1);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) seen_valid = 1'b1;
      cyc(1);
    end
    chk("calc_rst_no_valid", 32'(seen_valid), 32'd0);
    chk("calc_rst_a",        32'(op_a),       32'd0);
    chk("calc_rst_b",        32'(op_b),       32'd0);
    chk("calc_rst_result",   32'(result),     32'd0);
    chk("calc_rst_want_a",   32'(want_a),     32'd1);

    // randomized buttons, switches and occasional reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) sw = W'($urandom);
      if ($urandom_range(0, 5) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
